// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the number of stream bytes that make up one instruction word.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int INST_BYTES = 2;

endpackage

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream, high byte first, at word
// addresses 0..load_len-1, and keeps the core in reset until that is done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int INST_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic [7:0]        byte_in_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [INST_W-1:0] im_wdata_o,
  output logic              core_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int BYTE_W = INST_W / INST_BYTES;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [INST_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                byte_ready_q, im_we_q, core_hold_q, done_q;
  logic [ADDR_W:0]     cnt_inc;

  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          if (load_len_i == '0) begin
            state_d = DONE;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else if (load_len_i > DEPTH) begin
            err_d = 1'b1;
          end else begin
            len_d   = load_len_i;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = HI;
          end
        end
      end
      HI: begin
        if (byte_valid_i && byte_ready_q) begin
          wdata_d[INST_W-1 -: BYTE_W] = byte_in_i;
          state_d = LO;
        end
      end
      LO: begin
        if (byte_valid_i && byte_ready_q) begin
          wdata_d[BYTE_W-1:0] = byte_in_i;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Counter is one bit wider than the address so a full-depth load ends cleanly.
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? DONE : HI;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      byte_ready_q <= (state_d == HI) || (state_d == LO);
      im_we_q      <= (state_d == WRITE);
      core_hold_q  <= (state_d != DONE);
      done_q       <= (state_d == DONE);
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign im_we_o      = im_we_q;
  assign im_addr_o    = cnt_q[ADDR_W-1:0];
  assign im_wdata_o   = wdata_q;
  assign core_hold_o  = core_hold_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a transaction-level model (expected word list and
// load phase) checked against the DUT on every falling clock edge.
module tb_imem_loader;

  localparam int ADDR_W = 12;
  localparam int INST_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int REQ_RESET  = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_EMPTY  = 2;
  localparam int REQ_REJECT = 3;

  localparam int PH_IDLE = 0;
  localparam int PH_BUSY = 1;
  localparam int PH_DONE = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [INST_W-1:0] im_wdata;
  logic              core_hold;
  logic              done;
  logic              err;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  byteBuf  [0:2*DEPTH-1];
  logic [15:0] expWords [0:DEPTH-1];
  int          expLen = 0;

  int reqSeq  = 0;
  int reqKind = REQ_RESET;

  int          phase       = PH_IDLE;
  logic        expErr      = 1'b0;
  int          wrPtr       = 0;
  bit          pendingDone = 0;
  logic        prevWe      = 1'b0;
  int          writeCount  = 0;
  logic [11:0] lastAddr    = '0;
  logic [11:0] gotAddr [0:7];
  logic [15:0] gotData [0:7];

  imem_loader #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .load_len_i   (load_len),
    .byte_in_i    (byte_in),
    .byte_valid_i (byte_valid),
    .byte_ready_o (byte_ready),
    .im_we_o      (im_we),
    .im_addr_o    (im_addr),
    .im_wdata_o   (im_wdata),
    .core_hold_o  (core_hold),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected words follow directly from the byte order: word k = {b[2k], b[2k+1]}.
  task automatic buildWords(input int len);
    for (int k = 0; k < len; k++) expWords[k] = {byteBuf[2*k], byteBuf[2*k+1]};
    expLen = len;
  endtask

  task automatic prepareRandom(input int len);
    for (int i = 0; i < 2*len; i++) byteBuf[i] = 8'($urandom);
    buildWords(len);
  endtask

  task automatic applyStimulus(input logic [ADDR_W:0] len, input int kind);
    @(posedge clk); #1;
    start    = 1'b1;
    load_len = len;
    @(posedge clk); #1;
    start   = 1'b0;
    reqKind = kind;
    reqSeq++;
  endtask

  task automatic waitDone(input int len);
    bit seen = 0;
    int cyc  = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk); #1;
      if (done) seen = 1;
      cyc++;
    end
    checkOutput("done_reached", 32'(seen), 32'd1);
    checkOutput("write_count", 32'(writeCount), 32'(len));
  endtask

  task automatic runLoad(input int len, input bit gaps, input bit injectStart);
    int idx    = 0;
    int budget = 8*len + 50;
    applyStimulus((ADDR_W+1)'(len), REQ_LOAD);
    while (idx < 2*len && budget > 0) begin
      @(posedge clk); #1;
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in    = byteBuf[idx];
      start      = injectStart && ($urandom_range(0, 3) == 0);
      load_len   = (ADDR_W+1)'($urandom_range(1, 9));
      @(negedge clk);
      if (byte_valid && byte_ready) idx++;
      budget--;
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    checkOutput("bytes_consumed", 32'(idx), 32'(2*len));
    waitDone(len);
  endtask

  // Compare process: applies model requests, then checks every cycle.
  initial begin : compareProc
    int seenSeq = 0;
    forever begin
      @(negedge clk);
      if (reqSeq != seenSeq) begin
        seenSeq = reqSeq;
        case (reqKind)
          REQ_RESET:  begin phase = PH_IDLE; expErr = 1'b0; pendingDone = 0; end
          REQ_LOAD:   begin phase = PH_BUSY; expErr = 1'b0; wrPtr = 0; writeCount = 0; pendingDone = 0; end
          REQ_EMPTY:  begin phase = PH_DONE; expErr = 1'b0; writeCount = 0; end
          REQ_REJECT: expErr = 1'b1;
          default: ;
        endcase
      end
      if (pendingDone) begin
        phase       = PH_DONE;
        pendingDone = 0;
      end
      checkOutput("err", 32'(err), 32'(expErr));
      if (phase != PH_BUSY) begin
        checkOutput("byte_ready_quiet", 32'(byte_ready), 32'd0);
        checkOutput("core_hold", 32'(core_hold), 32'(phase == PH_IDLE));
        checkOutput("done", 32'(done), 32'(phase == PH_DONE));
      end else begin
        checkOutput("core_hold_busy", 32'(core_hold), 32'd1);
        checkOutput("done_busy", 32'(done), 32'd0);
      end
      if (im_we) begin
        if (phase != PH_BUSY || wrPtr >= expLen) begin
          checkOutput("spurious_we", 32'(im_we), 32'd0);
        end else begin
          checkOutput("wr_addr", 32'(im_addr), 32'(wrPtr));
          checkOutput("wr_data", 32'(im_wdata), 32'(expWords[wrPtr]));
          checkOutput("ready_in_write", 32'(byte_ready), 32'd0);
          checkOutput("we_single_cycle", 32'(prevWe), 32'd0);
          if (writeCount < 8) begin
            gotAddr[writeCount] = im_addr;
            gotData[writeCount] = im_wdata;
          end
          lastAddr = im_addr;
          writeCount++;
          wrPtr++;
          if (wrPtr == expLen) pendingDone = 1;
        end
      end
      prevWe = im_we;
    end
  end

  initial begin : stimulusProc
    rst_n      = 1'b0;
    start      = 1'b0;
    load_len   = '0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: held, nothing written.
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_core_hold", 32'(core_hold), 32'd1);
    checkOutput("reset_wdata", 32'(im_wdata), 32'd0);

    // Oversized request from IDLE is rejected.
    applyStimulus((ADDR_W+1)'(DEPTH + 1), REQ_REJECT);
    repeat (3) @(negedge clk);
    checkOutput("reject_err", 32'(err), 32'd1);
    checkOutput("reject_hold", 32'(core_hold), 32'd1);

    // Three-word load with byte_valid held high.
    byteBuf[0] = 8'h12; byteBuf[1] = 8'h34; byteBuf[2] = 8'h56;
    byteBuf[3] = 8'h78; byteBuf[4] = 8'h9A; byteBuf[5] = 8'hBC;
    buildWords(3);
    runLoad(3, 1'b0, 1'b0);
    checkOutput("pin_data0", 32'(gotData[0]), 32'h1234);
    checkOutput("pin_data1", 32'(gotData[1]), 32'h5678);
    checkOutput("pin_data2", 32'(gotData[2]), 32'h9ABC);
    checkOutput("pin_addr2", 32'(gotAddr[2]), 32'd2);
    checkOutput("pin_hold_done", 32'(core_hold), 32'd0);

    // Rejected start while DONE keeps DONE.
    applyStimulus((ADDR_W+1)'(DEPTH + 1), REQ_REJECT);
    repeat (2) @(negedge clk);
    checkOutput("reject_done_err", 32'(err), 32'd1);
    checkOutput("reject_done_done", 32'(done), 32'd1);

    // Same three words with random gaps and stray start pulses.
    runLoad(3, 1'b1, 1'b1);
    checkOutput("gap_data0", 32'(gotData[0]), 32'h1234);
    checkOutput("gap_data2", 32'(gotData[2]), 32'h9ABC);

    // Zero-length load goes straight to DONE.
    applyStimulus('0, REQ_EMPTY);
    repeat (4) @(negedge clk);
    checkOutput("empty_done", 32'(done), 32'd1);
    checkOutput("empty_writes", 32'(writeCount), 32'd0);

    // Reload one word from DONE.
    byteBuf[0] = 8'hAB; byteBuf[1] = 8'hCD;
    buildWords(1);
    runLoad(1, 1'b0, 1'b0);
    checkOutput("reload_data", 32'(gotData[0]), 32'hABCD);
    checkOutput("reload_addr", 32'(gotAddr[0]), 32'd0);

    for (int t = 0; t < 4; t++) begin
      int len = $urandom_range(1, 20);
      prepareRandom(len);
      runLoad(len, 1'b1, 1'b1);
    end

    // Full-depth load must end at the last address without wrapping.
    prepareRandom(DEPTH);
    runLoad(DEPTH, 1'b0, 1'b0);
    checkOutput("full_last_addr", 32'(lastAddr), 32'(DEPTH - 1));

    // Asynchronous reset after the high byte of a word.
    prepareRandom(2);
    applyStimulus((ADDR_W+1)'(2), REQ_LOAD);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_in    = 8'h5A;
    @(negedge clk);
    checkOutput("mid_ready_hi", 32'(byte_ready), 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    checkOutput("mid_hi_capture", 32'(im_wdata[15:8]), 32'h5A);
    rst_n   = 1'b0;
    reqKind = REQ_RESET;
    reqSeq++;
    #1;
    checkOutput("async_wdata", 32'(im_wdata), 32'd0);
    checkOutput("async_ready", 32'(byte_ready), 32'd0);
    checkOutput("async_hold", 32'(core_hold), 32'd1);
    checkOutput("async_addr", 32'(im_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    prepareRandom(2);
    runLoad(2, 1'b1, 1'b0);
    checkOutput("post_reset_addr0", 32'(gotAddr[0]), 32'd0);
    checkOutput("post_reset_addr1", 32'(gotAddr[1]), 32'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: the core's fetch path only reads instruction memory; this block fills it.
- Receives a byte stream over a valid/ready handshake and assembles 16-bit instructions, high byte first (opcode in bits 15:12).
- Writes each instruction to consecutive word addresses starting at 0.
- Holds the core in reset (core_hold) until the programmed number of words has been written.

Parameters:
ADDR_W, 12, instruction-memory word-address width; DEPTH = 2^ADDR_W words
INST_W, 16, instruction width; fixed at 2 bytes, other values unsupported

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin a load; sampled only in IDLE or DONE
load_len  input  ADDR_W+1  number of words to load; latched on accepted start
byte_in  input  8  stream byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte this cycle
im_we  output  1  instruction-memory write strobe, one cycle per word
im_addr  output  ADDR_W  write word address
im_wdata  output  INST_W  write data
core_hold  output  1  1 = core held in reset (drive rstPC / core reset)
done  output  1  load complete
err  output  1  last start rejected (load_len > DEPTH)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, word counter 0, im_we=0, im_addr=0, im_wdata=0, byte_ready=0, core_hold=1, done=0, err=0. Reset asserted mid-load aborts immediately; partial memory contents are left as written.
- States: IDLE, HI, LO, WRITE, DONE.
- IDLE: byte_ready=0, core_hold=1. On start:
  - load_len==0: go to DONE.
  - load_len>DEPTH: err=1, stay in IDLE.
  - Otherwise: latch load_len, clear counter and err, go to HI.
- HI: byte_ready=1. On byte_valid&byte_ready, capture byte_in into im_wdata[15:8] and go to LO.
- LO: byte_ready=1. On handshake, capture byte_in into im_wdata[7:0] and go to WRITE.
- WRITE: byte_ready=0, im_we=1 for exactly one cycle, im_addr=counter.
  - Next cycle: counter increments.
  - If counter+1==load_len, go to DONE; otherwise go to HI.
  - Counter is ADDR_W+1 bits, so a full-DEPTH load terminates without wrapping im_addr.
- Throughput: minimum 3 cycles per word (HI, LO, WRITE). byte_valid may stay high; bytes presented during WRITE are not consumed.
- DONE: core_hold=0, done=1, byte_ready=0; registered, so both are valid the cycle after the final WRITE.
  - A new start in DONE behaves exactly as in IDLE: same acceptance rules, and core_hold=1, done=0 from the next cycle.
  - A rejected start in DONE sets err=1 and stays in DONE.
- start in HI, LO or WRITE is ignored; load_len is used only when start is accepted.
- byte_valid while byte_ready=0 is ignored; no buffering.
- im_we is never asserted outside WRITE.

Decomposition:
- Shared package: state encoding enum (IDLE=0, HI=1, LO=2, WRITE=3, DONE=4), constant INST_BYTES=2.
- Single module, no sub-module; a separate byte-assembly sub-block is not warranted.

Test Plan:
- Reset then idle: rst low, then high with no start -> core_hold=1, done=0, byte_ready=0, im_we never pulses.
- Three-word load: start with load_len=3, bytes 0x12,0x34,0x56,0x78,0x9A,0xBC with byte_valid constantly high -> writes (0,0x1234), (1,0x5678), (2,0x9ABC), one im_we cycle each; done=1 and core_hold=0 the cycle after the third write.
- Backpressure/gaps: same load with byte_valid toggled randomly -> identical writes; no byte is lost or duplicated; start pulses mid-load have no effect.
- Limits: load_len=0 -> DONE with no writes. load_len=DEPTH+1 -> err=1, no writes, core_hold stays 1. load_len=DEPTH -> last write at address DEPTH-1, no wrap.
- Reload from DONE: second start with load_len=1 and bytes 0xAB,0xCD -> core_hold rises, then a single write (0,0xABCD), then done.
- Async reset mid-word: rst pulled low after the HI byte -> outputs return to reset values immediately; a fresh start then loads from address 0.
